// File: rtl/leta_pkg.sv
// Quadrature step encoding and the decode from one accepted {A,B} pair to the next.
// Pure combinational helpers; no latency, no flow control.
package leta_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    // Pairs are {A,B}; forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_t step_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] fwd;
        step_t      res;
        case (prev)
            2'b00:   fwd = 2'b01;
            2'b01:   fwd = 2'b11;
            2'b11:   fwd = 2'b10;
            default: fwd = 2'b00;
        endcase
        if (prev == cur)
            res = STEP_NONE;
        else if ((prev ^ cur) == 2'b11)
            res = STEP_ILL;
        else if (cur == fwd)
            res = STEP_UP;
        else
            res = STEP_DN;
        return res;
    endfunction

endpackage

// File: rtl/quad_chan.sv
// One quadrature channel: 2-flop sync, FILT-sample glitch filter, 4x decode, counter, sticky err (LETA_MULTI_ERR_EN).
// Input to count: 2 sync + FILT filter cycles; no backpressure, clr acts on the next edge.
module quad_chan
    import leta_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int SUB   = 1,
    parameter int FILT  = 2,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam int            CW   = CNT_W + SUB;
    localparam logic [CW-1:0] CMAX = '1;

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      acc_q, acc_d;
    logic [1:0][3:0] fcnt_q, fcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    step_t           step;

    // Each bit flips its accepted level only after FILT samples disagreeing with it.
    always_comb begin
        acc_d  = acc_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == 4'(FILT - 1)) begin
                acc_d[i]  = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    assign step = step_decode(acc_q, acc_d);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step == STEP_UP) begin
            if (SAT == 0 || cnt_q != CMAX)
                cnt_d = cnt_q + CW'(1);
        end else if (step == STEP_DN) begin
            if (SAT == 0 || cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_o = cnt_q[CW-1:SUB];

`ifdef LETA_MULTI_ERR_EN
    logic err_q, err_d;

    // A new illegal transition outranks a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (step == STEP_ILL)
            err_d = 1'b1;
        else if (clr_i)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/leta_multi.sv
// NCH-channel quadrature counter bank with addressed read/clear; err flags built only with LETA_MULTI_ERR_EN.
// data is registered one edge after rd; no backpressure, out-of-range addr reads 0 and ignores clr.
module leta_multi
    import leta_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int SUB   = 1,
    parameter int FILT  = 2,
    parameter int SAT   = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NCH-1:0]                         a,
    input  logic [NCH-1:0]                         b,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] addr,
    input  logic                                   rd,
    input  logic                                   clr,
    output logic [CNT_W-1:0]                       data,
    output logic [NCH-1:0]                         err
);

    localparam int AW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSLOT = 1 << AW;

    // Unpopulated address slots read as zero so the read mux needs no range check.
    logic [CNT_W-1:0] cnt [NSLOT];
    logic [NCH-1:0]   clr_sel;
    logic [CNT_W-1:0] data_q;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NCH) begin : g_chan
            assign clr_sel[g] = clr && (addr == AW'(g));

            quad_chan #(
                .CNT_W (CNT_W),
                .SUB   (SUB),
                .FILT  (FILT),
                .SAT   (SAT)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .a_i   (a[g]),
                .b_i   (b[g]),
                .clr_i (clr_sel[g]),
                .cnt_o (cnt[g]),
                .err_o (err[g])
            );
        end else begin : g_pad
            assign cnt[g] = '0;
        end
    end

    // Sampling the pre-edge count makes a same-cycle rd+clr return the old value.
    always_ff @(posedge clk) begin
        if (reset)
            data_q <= '0;
        else if (rd)
            data_q <= cnt[addr];
    end

    assign data = data_q;

endmodule

// File: tb/tb_leta_multi.sv
// Directed bench for leta_multi: three configurations share one stimulus stream,
// each with hand-computed expected readouts.
module tb_leta_multi;

    logic       clk;
    logic       reset;
    logic [3:0] a, b;
    logic [1:0] addr;
    logic       rd, clr;

    logic [7:0] data_def, data_w, data_s;
    logic [3:0] err_def, err_w;
    logic [2:0] err_s;

    int checks = 0;
    int errors = 0;

`ifdef LETA_MULTI_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // Defaults: NCH=4 CNT_W=8 SUB=1 FILT=2 wrap
    leta_multi u_def (
        .clk(clk), .reset(reset), .a(a), .b(b), .addr(addr),
        .rd(rd), .clr(clr), .data(data_def), .err(err_def)
    );

    // SUB=0 FILT=3 wrap
    leta_multi #(.NCH(4), .CNT_W(8), .SUB(0), .FILT(3), .SAT(0)) u_w (
        .clk(clk), .reset(reset), .a(a), .b(b), .addr(addr),
        .rd(rd), .clr(clr), .data(data_w), .err(err_w)
    );

    // SUB=0 FILT=3 saturating, only 3 channels so addr 3 is out of range
    leta_multi #(.NCH(3), .CNT_W(8), .SUB(0), .FILT(3), .SAT(1)) u_s (
        .clk(clk), .reset(reset), .a(a[2:0]), .b(b[2:0]), .addr(addr),
        .rd(rd), .clr(clr), .data(data_s), .err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] addr;
        logic       rd;
        logic       clr;
        int         hold;
        logic       chk;
        logic [7:0] e_def;
        logic [7:0] e_w;
        logic [7:0] e_s;
    } vec_t;

    vec_t       tv[$];
    logic [1:0] seq [4];

    function automatic vec_t mk(input logic rst, input logic [3:0] av, input logic [3:0] bv,
                                input logic [1:0] ad, input logic r, input logic c,
                                input int h, input logic k,
                                input logic [7:0] ed, input logic [7:0] ew, input logic [7:0] es);
        vec_t v;
        v.rst = rst; v.a = av; v.b = bv; v.addr = ad; v.rd = r; v.clr = c;
        v.hold = h; v.chk = k; v.e_def = ed; v.e_w = ew; v.e_s = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

        // ch0 takes 8 forward steps, ch3 takes 16 (preload to 0x10 on SUB=0)
        for (int k = 1; k <= 16; k++) begin
            logic [1:0] st;
            logic [1:0] s0;
            st = seq[k % 4];
            s0 = (k <= 8) ? st : 2'b00;
            tv.push_back(mk(0, {st[1], 2'b00, s0[1]}, {st[0], 2'b00, s0[0]}, 0, 0, 0, 4, 0, 0, 0, 0));
        end
        tv.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 1, 1, 8'h04, 8'h08, 8'h08));
        tv.push_back(mk(0, 4'h0, 4'h0, 3, 1, 0, 1, 1, 8'h08, 8'h10, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 3, 1, 1, 1, 1, 8'h08, 8'h10, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 3, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 1, 1, 8'h04, 8'h08, 8'h08));
        // ch1 one reverse step from zero; data must hold with rd low
        tv.push_back(mk(0, 4'h2, 4'h0, 0, 0, 0, 8, 1, 8'h04, 8'h08, 8'h08));
        tv.push_back(mk(0, 4'h2, 4'h0, 1, 1, 0, 1, 1, 8'hFF, 8'hFF, 8'h00));
        // ch2 2-cycle glitch on A from 00: rejected by FILT=3, dropped-then-up if mis-filtered on SAT
        tv.push_back(mk(0, 4'h6, 4'h0, 0, 0, 0, 2, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h2, 4'h0, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h2, 4'h0, 2, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h2, 4'h4, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h2, 4'h4, 2, 1, 0, 1, 1, 8'h00, 8'h01, 8'h01));
        tv.push_back(mk(0, 4'h6, 4'h4, 0, 0, 0, 2, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h2, 4'h4, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h2, 4'h4, 2, 1, 0, 1, 1, 8'h00, 8'h01, 8'h01));
        tv.push_back(mk(0, 4'h6, 4'h4, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h6, 4'h4, 2, 1, 0, 1, 1, 8'h01, 8'h02, 8'h02));
        // ch1 forward from 0xFF wraps to 0 (SAT=1 climbs from 0 to 1)
        tv.push_back(mk(0, 4'h4, 4'h4, 0, 0, 0, 8, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h4, 4'h4, 1, 1, 0, 1, 1, 8'h00, 8'h00, 8'h01));
        // clr at addr 3 is a no-op on the 3-channel build, read there gives 0
        tv.push_back(mk(0, 4'h4, 4'h4, 3, 0, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'h4, 4'h4, 1, 1, 0, 1, 1, 8'h00, 8'h00, 8'h01));
        tv.push_back(mk(0, 4'h4, 4'h4, 3, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h4, 4'h4, 2, 1, 0, 1, 1, 8'h01, 8'h02, 8'h02));
        // reset with nonzero counts and data
        tv.push_back(mk(1, 4'h0, 4'h0, 2, 1, 1, 1, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 2, 1, 0, 8, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 1, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00));
        tv.push_back(mk(0, 4'h0, 4'h0, 0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00));

        reset = 1'b1; a = '0; b = '0; addr = '0; rd = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_def", data_def, 8'h00);
        chk("reset data_w", data_w, 8'h00);
        chk("reset data_s", data_s, 8'h00);
        chk("reset err_def", {4'b0, err_def}, 8'h00);

        foreach (tv[i]) begin
            reset = tv[i].rst; a = tv[i].a; b = tv[i].b; addr = tv[i].addr;
            rd = tv[i].rd; clr = tv[i].clr;
            repeat (tv[i].hold) @(posedge clk);
            #1;
            if (tv[i].chk) begin
                chk($sformatf("v%0d data_def", i), data_def, tv[i].e_def);
                chk($sformatf("v%0d data_w", i), data_w, tv[i].e_w);
                chk($sformatf("v%0d data_s", i), data_s, tv[i].e_s);
                chk($sformatf("v%0d err_def", i), {4'b0, err_def}, 8'h00);
                chk($sformatf("v%0d err_w", i), {4'b0, err_w}, 8'h00);
                chk($sformatf("v%0d err_s", i), {5'b0, err_s}, 8'h00);
            end
        end

        // ch0 jumps 00 -> 11: count must not move, err[0] set only in the err build
        reset = 1'b0; rd = 1'b0; clr = 1'b0; addr = 2'd0;
        a = 4'h1; b = 4'h1;
        repeat (8) @(posedge clk);
        #1;
        chk("ill err_def0", {7'b0, err_def[0]}, {7'b0, EXP_ERR});
        chk("ill err_w0", {7'b0, err_w[0]}, {7'b0, EXP_ERR});
        chk("ill err_s0", {7'b0, err_s[0]}, {7'b0, EXP_ERR});
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        chk("ill cnt_def", data_def, 8'h00);
        chk("ill cnt_w", data_w, 8'h00);
        chk("ill cnt_s", data_s, 8'h00);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr err_def", {4'b0, err_def}, 8'h00);
        chk("clr err_w", {4'b0, err_w}, 8'h00);
        chk("clr err_s", {5'b0, err_s}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
